// File: rtl/microseq_if.sv
// Sequencer bus: microcode ROM address/data plus the opcode handshake.
// Latency: n/a (signal bundle only).
// Backpressure: in_valid/in_ready; the sequencer stalls on a dispatch without in_valid.
//
// Members:
//   en        sequencing enable (env -> seq)
//   uinstr    ROM data for the current state (env -> seq)
//   in_valid  opcode source has data (env -> seq)
//   in_data   2-bit opcode (env -> seq)
//   state     current micro-state / ROM address (seq -> env)
//   in_ready  opcode consumed this cycle when in_valid (seq -> env)
//   done      one-cycle pulse after a return-to-0 step (seq -> env)
//   err       sticky illegal state/microinstruction flag (seq -> env)
//   disp_cnt  saturating count of accepted opcodes (seq -> env)
interface microseq_if;
  logic       en;
  logic [3:0] uinstr;
  logic       in_valid;
  logic [1:0] in_data;
  logic [3:0] state;
  logic       in_ready;
  logic       done;
  logic       err;
  logic [7:0] disp_cnt;

  modport master (
    input  en, uinstr, in_valid, in_data,
    output state, in_ready, done, err, disp_cnt
  );

  modport slave (
    output en, uinstr, in_valid, in_data,
    input  state, in_ready, done, err, disp_cnt
  );
endinterface

// File: rtl/microseq.sv
// Microprogram sequencer: 4-bit state register addressing a 16x4 microcode ROM.
// Latency: one micro-step per clk; ROM data is used combinationally in the same cycle.
// Backpressure: a dispatch microinstruction stalls in place until in_valid; en=0 freezes everything.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    microseq_if.master (ROM address/data, opcode handshake, status outputs)
module microseq (
  input  logic        clk,
  input  logic        rst_n,
  microseq_if.master  bus
);

  typedef enum logic [3:0] {
    UOP_INC    = 4'd0,
    UOP_DISP_A = 4'd1,
    UOP_DISP_B = 4'd2,
    UOP_JMP7   = 4'd3,
    UOP_RET    = 4'd4
  } uop_e;

  localparam logic [3:0] LAST_LEGAL = 4'd12;

  logic [3:0] state_q;
  logic       done_q;
  logic       err_q;
  logic [7:0] cnt_q;

  logic [3:0] nxt_state;
  logic       nxt_done;
  logic       set_err;
  logic       illegal_state;
  logic       is_disp;
  logic       ready;
  logic       xfer;

  function automatic logic [3:0] tab_a(input logic [1:0] op);
    case (op)
      2'd0:    return 4'd4;
      2'd1:    return 4'd5;
      default: return 4'd6;
    endcase
  endfunction

  function automatic logic [3:0] tab_b(input logic [1:0] op);
    case (op)
      2'd0:    return 4'd11;
      2'd1:    return 4'd12;
      2'd2:    return 4'd7;
      default: return 4'd0;
    endcase
  endfunction

  // in_ready never looks at in_valid, so the source may wait on it without a loop.
  always_comb begin
    illegal_state = (state_q > LAST_LEGAL);
    is_disp       = (bus.uinstr == UOP_DISP_A) || (bus.uinstr == UOP_DISP_B);
    ready         = bus.en && is_disp && !illegal_state;
    xfer          = ready && bus.in_valid;
  end

  // Next-state decode. A dispatch without in_valid keeps nxt_state = state_q (stall).
  always_comb begin
    nxt_state = state_q;
    nxt_done  = 1'b0;
    set_err   = 1'b0;
    if (illegal_state) begin
      nxt_state = 4'd0;
      set_err   = 1'b1;
    end else begin
      case (bus.uinstr)
        UOP_INC:    nxt_state = state_q + 4'd1;
        UOP_DISP_A: if (bus.in_valid) nxt_state = tab_a(bus.in_data);
        UOP_DISP_B: if (bus.in_valid) nxt_state = tab_b(bus.in_data);
        UOP_JMP7:   nxt_state = 4'd7;
        UOP_RET: begin
          nxt_state = 4'd0;
          nxt_done  = 1'b1;
        end
        default: begin
          nxt_state = 4'd0;
          set_err   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= 4'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else if (bus.en) begin
      state_q <= nxt_state;
      done_q  <= nxt_done;
      if (set_err) err_q <= 1'b1;
      if (xfer && (cnt_q != 8'hFF)) cnt_q <= cnt_q + 8'd1;
    end else begin
      // Frozen, but a pending done pulse still retires so it stays one cycle wide.
      done_q <= 1'b0;
    end
  end

  assign bus.state    = state_q;
  assign bus.in_ready = ready;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.disp_cnt = cnt_q;

endmodule

// File: tb/tb_microseq.sv
// Bench for microseq: a directed stimulus process pushes the expected output
// snapshot for each cycle; a negedge monitor pops and compares.
module tb_microseq;

  logic clk;
  logic rst_n;
  logic [3:0] rom [16];

  microseq_if bus ();

  microseq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  assign bus.uinstr = rom[bus.state];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [3:0] st;
    logic       rdy;
    logic       dn;
    logic       er;
    logic [7:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   step_id  = 0;
  bit   stim_done = 1'b0;

  // One cycle: drive inputs just after the edge, then queue what the
  // outputs must show for the rest of this cycle.
  task automatic step(input logic rn, input logic e, input logic v, input logic [1:0] d,
                      input logic [3:0] st, input logic rdy, input logic dn,
                      input logic er, input logic [7:0] cnt);
    exp_t x;
    @(posedge clk);
    #1;
    rst_n        = rn;
    bus.en       = e;
    bus.in_valid = v;
    bus.in_data  = d;
    x.id  = step_id;
    x.st  = st;
    x.rdy = rdy;
    x.dn  = dn;
    x.er  = er;
    x.cnt = cnt;
    exp_q.push_back(x);
    step_id++;
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.state !== e.st || bus.in_ready !== e.rdy || bus.done !== e.dn ||
            bus.err !== e.er || bus.disp_cnt !== e.cnt) begin
          failures++;
          $display("FAIL step%0d: got state=%0d rdy=%b done=%b err=%b cnt=%0d, want state=%0d rdy=%b done=%b err=%b cnt=%0d",
                   e.id, bus.state, bus.in_ready, bus.done, bus.err, bus.disp_cnt,
                   e.st, e.rdy, e.dn, e.er, e.cnt);
        end
      end
    end
  end

  // Stimulus
  initial begin
    logic [3:0] seq [9];
    int c;

    for (int i = 0; i < 16; i++) rom[i] = 4'd0;
    rom[3]  = 4'd1;
    rom[4]  = 4'd3;
    rom[5]  = 4'd3;
    rom[10] = 4'd2;
    rom[11] = 4'd4;
    rom[12] = 4'd4;

    rst_n        = 1'b0;
    bus.en       = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 2'd0;

    // 1: reset, count up to the dispatch at 3, stall there
    step(0, 0, 0, 0,   0, 0, 0, 0, 0);
    step(1, 1, 0, 0,   0, 0, 0, 0, 0);
    step(1, 1, 0, 0,   1, 0, 0, 0, 0);
    step(1, 1, 0, 0,   2, 0, 0, 0, 0);
    repeat (5) step(1, 1, 0, 0,   3, 1, 0, 0, 0);

    // 2: table A op1 -> 5, jump 7, count to 10, table B op0 -> 11, return
    step(1, 1, 1, 1,   3, 1, 0, 0, 0);
    step(1, 1, 0, 0,   5, 0, 0, 0, 1);
    step(1, 1, 0, 0,   7, 0, 0, 0, 1);
    step(1, 1, 0, 0,   8, 0, 0, 0, 1);
    step(1, 1, 0, 0,   9, 0, 0, 0, 1);
    step(1, 1, 1, 0,  10, 1, 0, 0, 1);
    step(1, 1, 0, 0,  11, 0, 0, 0, 2);
    step(1, 1, 0, 0,   0, 0, 1, 0, 2);
    step(1, 1, 0, 0,   1, 0, 0, 0, 2);
    step(1, 1, 0, 0,   2, 0, 0, 0, 2);

    // 3: table A op3 -> 6, table B op3 -> 0 without done
    step(1, 1, 1, 3,   3, 1, 0, 0, 2);
    step(1, 1, 0, 0,   6, 0, 0, 0, 3);
    step(1, 1, 0, 0,   7, 0, 0, 0, 3);
    step(1, 1, 0, 0,   8, 0, 0, 0, 3);
    step(1, 1, 0, 0,   9, 0, 0, 0, 3);
    step(1, 1, 1, 3,  10, 1, 0, 0, 3);
    step(1, 1, 0, 0,   0, 0, 0, 0, 4);
    step(1, 1, 0, 0,   1, 0, 0, 0, 4);

    // 4: illegal microinstruction at state 2 -> 0, err sticky
    rom[2] = 4'd9;
    step(1, 1, 0, 0,   2, 0, 0, 0, 4);
    step(1, 1, 0, 0,   0, 0, 0, 1, 4);
    rom[2] = 4'd0;
    step(1, 1, 0, 0,   1, 0, 0, 1, 4);
    step(1, 1, 0, 0,   2, 0, 0, 1, 4);
    step(1, 1, 0, 0,   3, 1, 0, 1, 4);

    // 5: en=0 blocks the transfer; en=1 lets it through
    step(1, 0, 1, 1,   3, 0, 0, 1, 4);
    step(1, 0, 1, 1,   3, 0, 0, 1, 4);
    step(1, 1, 1, 1,   3, 1, 0, 1, 4);
    step(1, 1, 0, 0,   5, 0, 0, 1, 5);
    step(1, 1, 0, 0,   7, 0, 0, 1, 5);
    step(1, 1, 0, 0,   8, 0, 0, 1, 5);
    step(1, 1, 0, 0,   9, 0, 0, 1, 5);
    step(1, 1, 1, 0,  10, 1, 0, 1, 5);
    step(1, 1, 0, 0,  11, 0, 0, 1, 6);
    // done visible while frozen, then clears and does not re-fire
    step(1, 0, 0, 0,   0, 0, 1, 1, 6);
    step(1, 0, 0, 0,   0, 0, 0, 1, 6);
    step(1, 1, 0, 0,   0, 0, 0, 1, 6);

    // 6: stall at 10, then async reset between edges
    step(1, 1, 0, 0,   1, 0, 0, 1, 6);
    step(1, 1, 0, 0,   2, 0, 0, 1, 6);
    step(1, 1, 1, 2,   3, 1, 0, 1, 6);
    step(1, 1, 0, 0,   6, 0, 0, 1, 7);
    step(1, 1, 0, 0,   7, 0, 0, 1, 7);
    step(1, 1, 0, 0,   8, 0, 0, 1, 7);
    step(1, 1, 0, 0,   9, 0, 0, 1, 7);
    step(1, 1, 0, 0,  10, 1, 0, 1, 7);
    step(1, 1, 0, 0,  10, 1, 0, 1, 7);
    step(0, 1, 0, 0,   0, 0, 0, 0, 0);
    step(1, 0, 0, 0,   0, 0, 0, 0, 0);

    // 300 dispatches: 0,1,2,3(A op0 -> 4),4(jump 7),7,8,9,10(B op3 -> 0)
    seq[0] = 4'd0; seq[1] = 4'd1; seq[2] = 4'd2; seq[3] = 4'd3; seq[4] = 4'd4;
    seq[5] = 4'd7; seq[6] = 4'd8; seq[7] = 4'd9; seq[8] = 4'd10;
    c = 0;
    for (int it = 0; it < 150; it++) begin
      for (int k = 0; k < 9; k++) begin
        if (k == 3) begin
          step(1, 1, 1, 0,  seq[k], 1, 0, 0, 8'(c));
          if (c < 255) c++;
        end else if (k == 8) begin
          step(1, 1, 1, 3,  seq[k], 1, 0, 0, 8'(c));
          if (c < 255) c++;
        end else begin
          step(1, 1, 0, 0,  seq[k], 0, 0, 0, 8'(c));
        end
      end
    end
    step(1, 1, 0, 0,   0, 0, 0, 0, 255);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected snapshots left, want 0", exp_q.size());
    end
    stim_done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net in case the stimulus process never completes.
  initial begin
    #200000;
    if (!stim_done) begin
      $display("FAIL timeout: stimulus incomplete at step %0d, want complete", step_id);
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
    end
  end

endmodule
